r5p_lsu: RTL and testbench

R5P_LSU -- requirements
Module: r5p_lsu

---
 rtl/r5p_lsu.sv | 216 +++++++++++++++++++++
 tb/tb_r5p_lsu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_lsu.sv
// -----------------------------------------------------------------------------
// r5p_lsu -- load/store unit for a small RV32 core.
//
// Accepts one load or store from the core, formats it into a single
// word-aligned bus transfer with byte enables, and returns sign- or
// zero-extended load data. Misaligned and illegal-size requests complete
// without any bus activity and raise lsu_mal together with lsu_done.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   lsu_vld / lsu_rdy        core request handshake (rdy only while idle)
//   lsu_wen, lsu_siz,        store/load, size (byte/half/word), unsigned load,
//   lsu_uns, lsu_adr,        effective byte address, store data
//   lsu_wdt
//   lsu_done, lsu_mal,       one-cycle completion pulse, misaligned flag,
//   lsu_rdt                  extended load data (held between loads)
//   bus_vld / bus_rdy        bus transfer handshake
//   bus_wen, bus_adr,        write enable, word address, byte enables,
//   bus_ben, bus_wdt         lane-replicated write data
//   bus_rdt                  read data, valid the cycle after a read transfer
// -----------------------------------------------------------------------------
module r5p_lsu #(
    parameter int XW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lsu_vld,
    output logic          lsu_rdy,
    input  logic          lsu_wen,
    input  logic [1:0]    lsu_siz,
    input  logic          lsu_uns,
    input  logic [XW-1:0] lsu_adr,
    input  logic [XW-1:0] lsu_wdt,
    output logic          lsu_done,
    output logic          lsu_mal,
    output logic [XW-1:0] lsu_rdt,
    output logic          bus_vld,
    output logic          bus_wen,
    output logic [XW-1:0] bus_adr,
    output logic [3:0]    bus_ben,
    output logic [XW-1:0] bus_wdt,
    input  logic          bus_rdy,
    input  logic [XW-1:0] bus_rdt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      off_q, off_d;     // byte offset within the word
    logic [1:0]      siz_q, siz_d;
    logic            uns_q, uns_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;
    logic            mal_q, mal_d;
    logic [XW-1:0]   rdt_q, rdt_d;
    logic            bvld_q, bvld_d;
    logic            bwen_q, bwen_d;
    logic [XW-1:0]   badr_q, badr_d;
    logic [3:0]      bben_q, bben_d;
    logic [XW-1:0]   bwdt_q, bwdt_d;

    // Access is misaligned when the offset is not a multiple of the size;
    // size 3 is never legal.
    function automatic logic is_mal(input logic [1:0] siz, input logic [1:0] off);
        case (siz)
            2'd0:    is_mal = 1'b0;
            2'd1:    is_mal = off[0];
            2'd2:    is_mal = (off != 2'b00);
            default: is_mal = 1'b1;
        endcase
    endfunction

    // Byte enables for an aligned access of the given size at the given offset.
    function automatic logic [3:0] fmt_ben(input logic [1:0] siz, input logic [1:0] off);
        case (siz)
            2'd0:    fmt_ben = 4'b0001 << off;
            2'd1:    fmt_ben = 4'b0011 << off;
            default: fmt_ben = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the enables pick the right one.
    function automatic logic [XW-1:0] fmt_wdt(input logic [1:0] siz, input logic [XW-1:0] wdt);
        case (siz)
            2'd0:    fmt_wdt = {4{wdt[7:0]}};
            2'd1:    fmt_wdt = {2{wdt[15:0]}};
            default: fmt_wdt = wdt;
        endcase
    endfunction

    // Select the addressed field of the read word and sign/zero extend it.
    function automatic logic [XW-1:0] load_ext(input logic [1:0] siz, input logic [1:0] off,
                                               input logic uns, input logic [XW-1:0] rdt);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdt[7:0];
            2'd1:    b = rdt[15:8];
            2'd2:    b = rdt[23:16];
            default: b = rdt[31:24];
        endcase
        h = off[1] ? rdt[31:16] : rdt[15:0];
        case (siz)
            2'd0:    load_ext = {{24{~uns & b[7]}}, b};
            2'd1:    load_ext = {{16{~uns & h[15]}}, h};
            default: load_ext = rdt;
        endcase
    endfunction

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        siz_d   = siz_q;
        uns_d   = uns_q;
        mal_d   = 1'b0;
        rdt_d   = rdt_q;
        bvld_d  = 1'b0;
        bwen_d  = bwen_q;
        badr_d  = badr_q;
        bben_d  = bben_q;
        bwdt_d  = bwdt_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_vld) begin
                    if (is_mal(lsu_siz, lsu_adr[1:0])) begin
                        state_d = ST_DONE;
                        mal_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        off_d   = lsu_adr[1:0];
                        siz_d   = lsu_siz;
                        uns_d   = lsu_uns;
                        bvld_d  = 1'b1;
                        bwen_d  = lsu_wen;
                        badr_d  = {lsu_adr[XW-1:2], 2'b00};
                        bben_d  = fmt_ben(lsu_siz, lsu_adr[1:0]);
                        bwdt_d  = fmt_wdt(lsu_siz, lsu_wdt);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_rdy) begin
                    state_d = bwen_q ? ST_DONE : ST_RSP;
                end else begin
                    bvld_d  = 1'b1;
                end
            end
            ST_RSP: begin
                rdt_d   = load_ext(siz_q, off_q, uns_q, bus_rdt);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake and completion flags are decoded from the next state so
        // they appear registered in the same cycle as the state itself.
        rdy_d  = (state_d == ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset wipes any pending transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            off_q   <= 2'b00;
            siz_q   <= 2'b00;
            uns_q   <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            mal_q   <= 1'b0;
            rdt_q   <= '0;
            bvld_q  <= 1'b0;
            bwen_q  <= 1'b0;
            badr_q  <= '0;
            bben_q  <= 4'b0000;
            bwdt_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            siz_q   <= siz_d;
            uns_q   <= uns_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            mal_q   <= mal_d;
            rdt_q   <= rdt_d;
            bvld_q  <= bvld_d;
            bwen_q  <= bwen_d;
            badr_q  <= badr_d;
            bben_q  <= bben_d;
            bwdt_q  <= bwdt_d;
        end
    end

    assign lsu_rdy  = rdy_q;
    assign lsu_done = done_q;
    assign lsu_mal  = mal_q;
    assign lsu_rdt  = rdt_q;
    assign bus_vld  = bvld_q;
    assign bus_wen  = bwen_q;
    assign bus_adr  = badr_q;
    assign bus_ben  = bben_q;
    assign bus_wdt  = bwdt_q;

endmodule

// File: tb/tb_r5p_lsu.sv
// -----------------------------------------------------------------------------
// tb_r5p_lsu -- directed, table-driven bench for r5p_lsu, plus hand-written
// sequences for backpressure and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_r5p_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_vld, lsu_rdy, lsu_wen, lsu_uns;
    logic [1:0]  lsu_siz;
    logic [31:0] lsu_adr, lsu_wdt, lsu_rdt;
    logic        lsu_done, lsu_mal;
    logic        bus_vld, bus_wen, bus_rdy;
    logic [31:0] bus_adr, bus_wdt, bus_rdt;
    logic [3:0]  bus_ben;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_rdt;

    typedef struct {
        logic        wen;
        logic [1:0]  siz;
        logic        uns;
        logic [31:0] adr;
        logic [31:0] wdt;
        logic [31:0] brdt;
        logic        exp_mal;
        logic [31:0] exp_badr;
        logic [3:0]  exp_ben;
        logic [31:0] exp_bwdt;
        logic [31:0] exp_rdt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    r5p_lsu #(.XW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .lsu_vld  (lsu_vld),
        .lsu_rdy  (lsu_rdy),
        .lsu_wen  (lsu_wen),
        .lsu_siz  (lsu_siz),
        .lsu_uns  (lsu_uns),
        .lsu_adr  (lsu_adr),
        .lsu_wdt  (lsu_wdt),
        .lsu_done (lsu_done),
        .lsu_mal  (lsu_mal),
        .lsu_rdt  (lsu_rdt),
        .bus_vld  (bus_vld),
        .bus_wen  (bus_wen),
        .bus_adr  (bus_adr),
        .bus_ben  (bus_ben),
        .bus_wdt  (bus_wdt),
        .bus_rdy  (bus_rdy),
        .bus_rdt  (bus_rdt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Apply one vector starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        bit          done_seen;
        bit          saw_vld;
        bit          xfer_prev;
        logic [31:0] exp_rdt;
        exp_rdt = (!v.wen && !v.exp_mal) ? v.exp_rdt : last_rdt;
        chk("rdy_idle", idx, {31'd0, lsu_rdy}, 32'd1);
        lsu_vld = 1'b1;
        lsu_wen = v.wen;
        lsu_siz = v.siz;
        lsu_uns = v.uns;
        lsu_adr = v.adr;
        lsu_wdt = v.wdt;
        @(posedge clk);
        @(negedge clk);
        // Garbage on the request inputs must be ignored once accepted.
        lsu_vld = 1'b0;
        lsu_wen = ~v.wen;
        lsu_siz = 2'($urandom);
        lsu_uns = ~v.uns;
        lsu_adr = $urandom;
        lsu_wdt = $urandom;
        cyc = 1;
        done_seen = 1'b0;
        saw_vld = 1'b0;
        xfer_prev = 1'b0;
        while (!done_seen && cyc <= 20) begin
            bus_rdt = xfer_prev ? v.brdt : 32'hDEAD_BEEF;
            xfer_prev = bus_vld && bus_rdy;
            if (bus_vld && !saw_vld) begin
                saw_vld = 1'b1;
                chk("vld_lat", idx, cyc, 32'd1);
                chk("bus_adr", idx, bus_adr, v.exp_badr);
                chk("bus_ben", idx, {28'd0, bus_ben}, {28'd0, v.exp_ben});
                chk("bus_wdt", idx, bus_wdt, v.exp_bwdt);
                chk("bus_wen", idx, {31'd0, bus_wen}, {31'd0, v.wen});
            end
            if (lsu_done) begin
                done_seen = 1'b1;
                chk("done_lat", idx, cyc, v.exp_lat);
                chk("lsu_mal", idx, {31'd0, lsu_mal}, {31'd0, v.exp_mal});
                chk("lsu_rdt", idx, lsu_rdt, exp_rdt);
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        if (!done_seen) begin
            n_chk++;
            $display("FAIL done_timeout[%0d]: got no lsu_done expected pulse", idx);
        end
        chk("saw_vld", idx, {31'd0, saw_vld}, {31'd0, ~v.exp_mal});
        last_rdt = exp_rdt;
        bus_rdt = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("done_one", idx, {31'd0, lsu_done}, 32'd0);
        chk("rdy_back", idx, {31'd0, lsu_rdy}, 32'd1);
    endtask

    initial begin
        //          wen   siz   uns   adr           wdt           brdt          mal   badr          ben      bwdt          rdt           lat
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF12, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 3};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        2};
        vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'hF00D_1234, 1'b0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0000_F00D, 3};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0,        32'h1234_8A56, 1'b0, 32'h0000_0010, 4'b0010, 32'h0,        32'h0000_008A, 3};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0400, 32'h0,        32'h0000_8001, 1'b0, 32'h0000_0400, 4'b0011, 32'h0,        32'hFFFF_8001, 3};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0,        32'hCAFE_BABE, 1'b0, 32'h1000_0008, 4'b1111, 32'h0,        32'hCAFE_BABE, 3};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'hAABB_CC5A, 32'h0,        1'b0, 32'h0000_0300, 4'b0010, 32'h5A5A_5A5A, 32'h0,        2};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0404, 32'h0102_0304, 32'h0,        1'b0, 32'h0000_0404, 4'b1111, 32'h0102_0304, 32'h0,        2};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_0203, 32'h5555_6666, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0,        32'h0071_0000, 1'b0, 32'h0000_0000, 4'b0100, 32'h0,        32'h0000_0071, 3};

        rst = 1'b0;
        lsu_vld = 1'b0; lsu_wen = 1'b0; lsu_siz = 2'd0; lsu_uns = 1'b0;
        lsu_adr = 32'h0; lsu_wdt = 32'h0;
        bus_rdy = 1'b1; bus_rdt = 32'hDEAD_BEEF;
        last_rdt = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_rdy",  0, {31'd0, lsu_rdy},  32'd1);
        chk("rst_done", 0, {31'd0, lsu_done}, 32'd0);
        chk("rst_mal",  0, {31'd0, lsu_mal},  32'd0);
        chk("rst_bvld", 0, {31'd0, bus_vld},  32'd0);
        chk("rst_bwen", 0, {31'd0, bus_wen},  32'd0);
        chk("rst_ben",  0, {28'd0, bus_ben},  32'd0);
        chk("rst_rdt",  0, lsu_rdt,           32'd0);
        chk("rst_badr", 0, bus_adr,           32'd0);
        chk("rst_bwdt", 0, bus_wdt,           32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure on a word store: 5 stalled cycles, request inputs toggling.
        bus_rdy = 1'b0;
        lsu_vld = 1'b1; lsu_wen = 1'b1; lsu_siz = 2'd2; lsu_uns = 1'b0;
        lsu_adr = 32'h0000_0500; lsu_wdt = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        lsu_wen = 1'b0; lsu_siz = 2'd0; lsu_adr = 32'h0000_0777; lsu_wdt = 32'hFFFF_FFFF;
        for (int c = 1; c <= 5; c++) begin
            chk("bp_vld",  c, {31'd0, bus_vld},  32'd1);
            chk("bp_adr",  c, bus_adr,           32'h0000_0500);
            chk("bp_ben",  c, {28'd0, bus_ben},  32'h0000_000F);
            chk("bp_wdt",  c, bus_wdt,           32'h5555_AAAA);
            chk("bp_wen",  c, {31'd0, bus_wen},  32'd1);
            chk("bp_rdy",  c, {31'd0, lsu_rdy},  32'd0);
            chk("bp_done", c, {31'd0, lsu_done}, 32'd0);
            if (c < 5) @(negedge clk);
        end
        @(negedge clk);
        chk("bp_vld6", 6, {31'd0, bus_vld}, 32'd1);
        bus_rdy = 1'b1;
        @(negedge clk);
        chk("bp_done7", 7, {31'd0, lsu_done}, 32'd1);
        chk("bp_mal7",  7, {31'd0, lsu_mal},  32'd0);
        chk("bp_vld7",  7, {31'd0, bus_vld},  32'd0);
        chk("bp_rdy7",  7, {31'd0, lsu_rdy},  32'd0);
        chk("bp_rdt7",  7, lsu_rdt,           last_rdt);
        lsu_vld = 1'b0;
        @(negedge clk);
        chk("bp_done8", 8, {31'd0, lsu_done}, 32'd0);
        chk("bp_rdy8",  8, {31'd0, lsu_rdy},  32'd1);

        // Reset while a load is in RSP, then a request in the first cycle out of reset.
        lsu_vld = 1'b1; lsu_wen = 1'b0; lsu_siz = 2'd2; lsu_uns = 1'b0; lsu_adr = 32'h0000_0600;
        @(posedge clk);
        @(negedge clk);
        lsu_vld = 1'b0;
        chk("rr_vld1", 1, {31'd0, bus_vld}, 32'd1);
        @(negedge clk);
        chk("rr_vld2", 2, {31'd0, bus_vld}, 32'd0);
        bus_rdt = 32'h1111_2222;
        rst = 1'b0;
        @(negedge clk);
        chk("rr_done", 3, {31'd0, lsu_done}, 32'd0);
        chk("rr_rdt",  3, lsu_rdt,           32'd0);
        chk("rr_vld3", 3, {31'd0, bus_vld},  32'd0);
        chk("rr_rdy",  3, {31'd0, lsu_rdy},  32'd1);
        last_rdt = 32'h0;
        bus_rdt = 32'hDEAD_BEEF;
        rst = 1'b1;
        lsu_vld = 1'b1; lsu_siz = 2'd3; lsu_adr = 32'h0;
        @(negedge clk);
        chk("rr_first_done", 4, {31'd0, lsu_done}, 32'd1);
        chk("rr_first_mal",  4, {31'd0, lsu_mal},  32'd1);
        chk("rr_first_rdt",  4, lsu_rdt,           32'd0);
        lsu_vld = 1'b0;
        @(negedge clk);

        // Reset while a store is stalled in REQ: bus_vld drops, no completion.
        bus_rdy = 1'b0;
        lsu_vld = 1'b1; lsu_wen = 1'b1; lsu_siz = 2'd0; lsu_adr = 32'h0000_0700; lsu_wdt = 32'h0000_0099;
        @(posedge clk);
        @(negedge clk);
        lsu_vld = 1'b0;
        chk("rq_vld1", 1, {31'd0, bus_vld}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rq_vld2",  2, {31'd0, bus_vld},  32'd0);
        chk("rq_done2", 2, {31'd0, lsu_done}, 32'd0);
        chk("rq_ben2",  2, {28'd0, bus_ben},  32'd0);
        rst = 1'b1;
        bus_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rq_done4", 4, {31'd0, lsu_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
